mem_sched: RTL and testbench
============================

# mem_sched

Single-port scheduler that shares the one `slowmem` port among four requesters: instruction fetch for pid 0 and pid 1, and data load/store for pid 0 and pid 1. It sits between the two-thread pipeline and `slowmem` and owns `strobe`/`rnotw`/`addr`/`wdata`. It serialises transactions, so `slowmem` never sees overlapping requests. It returns read data to the requester that was granted.

## Interface
Parameters:
- `TIMEOUT`, 16: RDWAIT cycles allowed before a read is abandoned. Used only when the timeout feature is compiled in.
- `MEMDELAY`, 4: `slowmem` read latency in cycles. Sets the mfc ignore window.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  asynchronous active-low reset.
- `req`  in  4  level requests. Bit 0 = fetch pid0, 1 = fetch pid1, 2 = data pid0, 3 = data pid1.
- `rnotw`  in  4  per-requester direction: 1 = read, 0 = write. Bits 0 and 1 must be 1.
- `addr`  in  64  four 16-bit addresses; requester i uses bits [16i+15:16i].
- `wdata`  in  64  four 16-bit write words, same packing as `addr`.
- `done`  out  4  one-cycle completion pulse per requester.
- `rdata`  out  16  read data. Valid only in the cycle a read requester's `done` bit is high.
- `err`  out  1  high together with `done` when a read timed out.
- `busy`  out  1  high in any state other than IDLE.
- `mem_addr`  out  16  registered address to `slowmem`.
- `mem_wdata`  out  16  registered write data to `slowmem`.
- `mem_rnotw`  out  1  registered direction to `slowmem`.
- `mem_strobe`  out  1  registered strobe to `slowmem`.
- `mem_mfc`  in  1  memory-function-complete from `slowmem`.
- `mem_rdata`  in  16  read data from `slowmem`.

## Operation
- States: IDLE, ISSUE, RDWAIT, DONE.
- IDLE. Select a winner among eligible `req` bits.
  - Eligible means `req` is high and that requester's `done` bit is not high in the current cycle.
  - Data bits [3:2] beat fetch bits [1:0].
  - Within a class, round-robin on a 1-bit pointer: the pid not granted last in that class wins ties.
  - On a grant, latch the requester index, drive `mem_addr`/`mem_wdata`/`mem_rnotw` from that requester, set `mem_strobe` to 1, and go to ISSUE.
  - Update the class pointer on the grant.
- ISSUE. Drop `mem_strobe` to 0 and set `mem_rnotw` to 1.
  - Write: go to DONE and pulse `done[i]`.
  - Read: go to RDWAIT and clear the wait counter.
- RDWAIT. Increment the wait counter every cycle.
  - While the counter is below `MEMDELAY-1`, ignore `mem_mfc`. This guards against a stale mfc left over from before a reset.
  - Once the counter reaches that value, `mem_mfc=1` captures `mem_rdata` into `rdata`, pulses `done[i]`, and moves to DONE.
- DONE. Stay one cycle, then return to IDLE. `done` is registered, so it is high during this cycle.
- Outside ISSUE, `mem_strobe` stays 0, so a new `slowmem` read can never restart a pending one.
- The requester must hold `addr`, `wdata` and `rnotw` stable from its `req` rising until `done`.
  - It may keep `req` high after `done` to request a back-to-back transaction.
- Async reset (any state, including mid-read):
  - State goes to IDLE.
  - `mem_strobe` = 0, `mem_rnotw` = 1, `mem_addr` = 0, `mem_wdata` = 0.
  - `done` = 0, `rdata` = 0, `err` = 0, `busy` = 0.
  - Both round-robin pointers go to pid0, the wait counter to 0.
  - Any transaction in flight is dropped with no `done`.

## Timing
- Edge 0 is the edge at which IDLE samples the winning `req`.
- Write:
  - `mem_strobe=1`, `mem_rnotw=0` after edge 0.
  - `slowmem` writes at edge 1.
  - `done[i]` is high after edge 1 for one cycle.
  - Next grant at edge 2 at the earliest.
- Read:
  - `mem_strobe=1`, `mem_rnotw=1` after edge 0.
  - `slowmem` captures at edge 1.
  - `mem_mfc` is high after edge 5.
  - Captured at edge 6: `done[i]` and `rdata` valid after edge 6.
  - Next grant at edge 7.
- A requester that arrives during a transaction waits. It is not queued beyond its held `req`.

## Configuration
- `MEMSCHED_TIMEOUT_EN` defined:
  - When the RDWAIT counter reaches `TIMEOUT` with no accepted mfc, pulse `done[i]` with `err=1` and `rdata=16'hFFFF`, then go to DONE.
  - A late mfc arriving in IDLE is ignored.
- `MEMSCHED_TIMEOUT_EN` undefined:
  - RDWAIT waits indefinitely.
  - `err` is tied to 0.
  - The counter saturates at `MEMDELAY-1`.

## Test plan
- Single read. `req=4'b0001`, `addr[15:0]=16'h0000`, `m[0]=16'h1234`. Expected: strobe after edge 0, `done=4'b0001` after edge 6, `rdata=16'h1234`.
- Write then read. `req[2]` write with `addr=16'h0010`, `wdata=16'hBEEF`. Expected: `done[2]` after edge 1. Then a `req[2]` read of `16'h0010` returns `16'hBEEF`.
- Priority. Raise `req=4'b0101` together (data pid0 and fetch pid0). Expected: grant order is data pid0 first, then fetch pid0 at edge 7.
- Round-robin. Hold `req=4'b0011`. Expected: `done` alternates 0001, 0010, 0001, … every 7 cycles.
- Reset mid-read. Assert `reset=0` after edge 3 of a read, release, then issue a new read to `16'h0001`. Expected: no `done` for the dropped read, no stale mfc acceptance, and the new read returns `m[1]`.
- Timeout (`MEMSCHED_TIMEOUT_EN`, `TIMEOUT=16`). Hold `mem_mfc=0`. Expected: after 16 RDWAIT cycles, `done[i]=1`, `err=1`, `rdata=16'hFFFF`.

Source files
------------

// File: rtl/mem_sched.sv
// mem_sched: serialises four requesters (fetch pid0/1, data pid0/1) onto one slowmem port.
// Optional read timeout is compiled in with `define MEMSCHED_TIMEOUT_EN.
module mem_sched #(
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned MEMDELAY = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  req_i,
   input  logic [3:0]  rnotw_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   output logic [3:0]  done_o,
   output logic [15:0] rdata_o,
   output logic        err_o,
   output logic        busy_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_rnotw_o,
   output logic        mem_strobe_o,
   input  logic        mem_mfc_i,
   input  logic [15:0] mem_rdata_i
);
   localparam int unsigned DW   = 16;
   localparam int unsigned CMAX = (TIMEOUT > MEMDELAY) ? TIMEOUT : MEMDELAY;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            fptr_q, fptr_d, dptr_q, dptr_d;
   logic [DW-1:0]   maddr_q, maddr_d, mwdata_q, mwdata_d, rdata_q, rdata_d;
   logic            mrnotw_q, mrnotw_d, strobe_q, strobe_d, busy_q, busy_d;
   logic [3:0]      done_q, done_d;
   logic            mfc_ok_c;
   logic [3:0]      elig_c;
   logic            gnt_c;
   logic [1:0]      gnt_idx_c;

   // Fixed priority data over fetch; 1-bit round-robin within each class.
   always_comb begin
      elig_c    = req_i & ~done_q;
      gnt_c     = 1'b0;
      gnt_idx_c = 2'd0;
      if (elig_c[3:2] != 2'b00) begin
         gnt_c     = 1'b1;
         gnt_idx_c = {1'b1, (elig_c[3:2] == 2'b11) ? dptr_q : elig_c[3]};
      end else if (elig_c[1:0] != 2'b00) begin
         gnt_c     = 1'b1;
         gnt_idx_c = {1'b0, (elig_c[1:0] == 2'b11) ? fptr_q : elig_c[1]};
      end
   end

   // A stale mfc (e.g. left from before a reset) is ignored until the read latency has elapsed.
   assign mfc_ok_c = mem_mfc_i && (cnt_q >= CW'(MEMDELAY - 1));

`ifdef MEMSCHED_TIMEOUT_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      fptr_d   = fptr_q;
      dptr_d   = dptr_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      mrnotw_d = mrnotw_q;
      strobe_d = 1'b0;
      done_d   = 4'b0000;
      rdata_d  = rdata_q;
`ifdef MEMSCHED_TIMEOUT_EN
      err_d    = 1'b0;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (gnt_c) begin
               state_d  = S_ISSUE;
               idx_d    = gnt_idx_c;
               maddr_d  = addr_i[{gnt_idx_c, 4'd0} +: DW];
               mwdata_d = wdata_i[{gnt_idx_c, 4'd0} +: DW];
               mrnotw_d = rnotw_i[gnt_idx_c] | ~gnt_idx_c[1];
               strobe_d = 1'b1;
               if (gnt_idx_c[1]) dptr_d = ~gnt_idx_c[0];
               else              fptr_d = ~gnt_idx_c[0];
            end
         end
         S_ISSUE: begin
            mrnotw_d = 1'b1;
            if (mrnotw_q) begin
               state_d = S_RDWAIT;
               cnt_d   = '0;
            end else begin
               state_d       = S_DONE;
               done_d[idx_q] = 1'b1;
            end
         end
         S_RDWAIT: begin
`ifdef MEMSCHED_TIMEOUT_EN
            cnt_d = cnt_q + CW'(1);
`else
            if (cnt_q < CW'(MEMDELAY - 1)) cnt_d = cnt_q + CW'(1);
`endif
            if (mfc_ok_c) begin
               state_d       = S_DONE;
               done_d[idx_q] = 1'b1;
               rdata_d       = mem_rdata_i;
            end
`ifdef MEMSCHED_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d       = S_DONE;
               done_d[idx_q] = 1'b1;
               rdata_d       = 16'hFFFF;
               err_d         = 1'b1;
            end
`endif
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         fptr_q   <= 1'b0;
         dptr_q   <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mrnotw_q <= 1'b1;
         strobe_q <= 1'b0;
         done_q   <= 4'b0000;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         fptr_q   <= fptr_d;
         dptr_q   <= dptr_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mrnotw_q <= mrnotw_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

`ifdef MEMSCHED_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign done_o       = done_q;
   assign rdata_o      = rdata_q;
   assign busy_o       = busy_q;
   assign mem_addr_o   = maddr_q;
   assign mem_wdata_o  = mwdata_q;
   assign mem_rnotw_o  = mrnotw_q;
   assign mem_strobe_o = strobe_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: directed vectors, corner-case sequences and a randomized scoreboard run for mem_sched.
module tb_mem_sched;
   localparam int TO  = 16;
   localparam int MD  = 4;

   logic        clk, rst_n;
   logic [3:0]  req_i, rnotw_i, done_o;
   logic [63:0] addr_i, wdata_i;
   logic [15:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        err_o, busy_o, mem_rnotw_o, mem_strobe_o, mem_mfc_i;

   mem_sched #(.TIMEOUT(TO), .MEMDELAY(MD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .rnotw_i(rnotw_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o),
      .err_o(err_o), .busy_o(busy_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rnotw_o(mem_rnotw_o),
      .mem_strobe_o(mem_strobe_o), .mem_mfc_i(mem_mfc_i), .mem_rdata_i(mem_rdata_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input int a);
      return 16'h1234 + 16'(a) * 16'h0111;
   endfunction

   // slowmem behavioural model: read data appears MD cycles after the strobe is captured
   typedef struct { int fire; logic [15:0] d; } pend_t;
   pend_t       pq[$];
   logic [15:0] m [256];
   int          cyc = 0;
   bit          mfc_block = 0;

   initial begin mem_mfc_i = 1'b0; mem_rdata_i = 16'h0; end

   always @(posedge clk) begin
      if (cyc == 0) for (int i = 0; i < 256; i++) m[i] = init_val(i);
      cyc = cyc + 1;
      mem_mfc_i <= 1'b0;
      if (pq.size() != 0 && pq[0].fire == cyc) begin
         mem_mfc_i   <= 1'b1;
         mem_rdata_i <= pq[0].d;
         pq.delete(0);
      end
      if (mem_strobe_o) begin
         if (mem_rnotw_o) begin
            if (!mfc_block) pq.push_back('{cyc + MD, m[mem_addr_o[7:0]]});
         end else begin
            m[mem_addr_o[7:0]] = mem_wdata_o;
         end
      end
   end

   logic [3:0]  rq, rw;
   logic [15:0] ra [4];
   logic [15:0] wd [4];

   task automatic apply();
      req_i   = rq;
      rnotw_i = rw;
      addr_i  = {ra[3], ra[2], ra[1], ra[0]};
      wdata_i = {wd[3], wd[2], wd[1], wd[0]};
   endtask

   task automatic do_reset();
      rq = 4'b0; apply();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  idx;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t tbl [7];

   task automatic run_vec(input int v);
      int   lat;
      logic [3:0] mask;
      logic [15:0] rdv;
      logic er;
      lat = -1; mask = 4'b0; rdv = 16'h0; er = 1'b0;
      rq = 4'b0; rq[tbl[v].idx] = 1'b1;
      rw[tbl[v].idx] = tbl[v].rd;
      ra[tbl[v].idx] = tbl[v].addr;
      wd[tbl[v].idx] = tbl[v].wdata;
      apply();
      for (int n = 0; n < 40 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (n == 0) begin
            chk($sformatf("v%0d_strobe", v), 32'(mem_strobe_o), 32'd1);
            chk($sformatf("v%0d_dir", v), 32'(mem_rnotw_o), 32'(tbl[v].rd));
            chk($sformatf("v%0d_maddr", v), 32'(mem_addr_o), 32'(tbl[v].addr));
            if (!tbl[v].rd) chk($sformatf("v%0d_mwdata", v), 32'(mem_wdata_o), 32'(tbl[v].wdata));
         end
         if (n == 1) begin
            chk($sformatf("v%0d_strobe_drop", v), 32'(mem_strobe_o), 32'd0);
            chk($sformatf("v%0d_dir_idle", v), 32'(mem_rnotw_o), 32'd1);
         end
         if (done_o != 4'b0) begin lat = n; mask = done_o; rdv = rdata_o; er = err_o; end
      end
      rq = 4'b0; apply();
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(tbl[v].lat));
      chk($sformatf("v%0d_done", v), 32'(mask), 32'(4'b1 << tbl[v].idx));
      chk($sformatf("v%0d_err", v), 32'(er), 32'd0);
      if (tbl[v].rd) chk($sformatf("v%0d_rdata", v), 32'(rdv), 32'(tbl[v].exp_rdata));
      repeat (2) @(posedge clk); #1;
   endtask

   // Multi-cycle sequences record done events relative to the first sampled edge.
   int          ev_n;
   int          ev_edge [8];
   logic [3:0]  ev_mask [8];
   logic [15:0] ev_data [8];

   task automatic watch(input int edges, input bit drop_on_done);
      ev_n = 0;
      for (int n = 0; n < edges; n++) begin
         @(posedge clk); #1;
         if (done_o != 4'b0 && ev_n < 8) begin
            ev_edge[ev_n] = n; ev_mask[ev_n] = done_o; ev_data[ev_n] = rdata_o; ev_n++;
            if (drop_on_done) begin rq = rq & ~done_o; apply(); end
         end
      end
   endtask

   // Random-phase reference model state
   logic [15:0] shad [256];

   initial begin
      int nf, ld, lg, li, exp_edge, exp_idx;
      bit fp, dp, exp_rd;
      logic [15:0] exp_data;
      rq = 4'b0; rw = 4'b1111;
      for (int i = 0; i < 4; i++) begin ra[i] = 16'h0; wd[i] = 16'h0; end
      apply();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_strobe", 32'(mem_strobe_o), 32'd0);
      chk("rst_rnotw", 32'(mem_rnotw_o), 32'd1);
      chk("rst_maddr", 32'(mem_addr_o), 32'd0);
      chk("rst_mwdata", 32'(mem_wdata_o), 32'd0);
      chk("rst_rdata", 32'(rdata_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      tbl[0] = '{2'd0, 1'b1, 16'h0000, 16'h0000, 6, 16'h1234};
      tbl[1] = '{2'd2, 1'b0, 16'h0010, 16'hBEEF, 1, 16'h0000};
      tbl[2] = '{2'd2, 1'b1, 16'h0010, 16'h0000, 6, 16'hBEEF};
      tbl[3] = '{2'd3, 1'b0, 16'h0020, 16'hCAFE, 1, 16'h0000};
      tbl[4] = '{2'd1, 1'b1, 16'h0020, 16'h0000, 6, 16'hCAFE};
      tbl[5] = '{2'd3, 1'b1, 16'h0005, 16'h0000, 6, 16'h1789};
      tbl[6] = '{2'd0, 1'b1, 16'h0010, 16'h0000, 6, 16'hBEEF};
      for (int v = 0; v < 7; v++) run_vec(v);

      // Priority: data pid0 beats fetch pid0; fetch granted at edge 7
      do_reset();
      rw = 4'b1111; ra[0] = 16'h0000; ra[2] = 16'h0003; rq = 4'b0101; apply();
      watch(20, 1'b1);
      chk("prio_events", 32'(ev_n), 32'd2);
      chk("prio_first", {ev_mask[0], 12'(ev_edge[0]), ev_data[0]}, {4'b0100, 12'd6, 16'h1567});
      chk("prio_second", {ev_mask[1], 12'(ev_edge[1]), ev_data[1]}, {4'b0001, 12'd13, 16'h1234});
      rq = 4'b0; apply(); repeat (2) @(posedge clk); #1;

      // Round-robin between fetch pid0/pid1 with requests held high
      do_reset();
      ra[0] = 16'h0001; ra[1] = 16'h0002; rq = 4'b0011; apply();
      watch(28, 1'b0);
      rq = 4'b0; apply();
      chk("rr_events", 32'(ev_n), 32'd4);
      for (int e = 0; e < 4; e++)
         chk($sformatf("rr_ev%0d", e), {ev_mask[e], 12'(ev_edge[e]), ev_data[e]},
             {((e % 2) == 0) ? 4'b0001 : 4'b0010, 12'(6 + 7 * e), ((e % 2) == 0) ? 16'h1345 : 16'h1456});
      repeat (3) @(posedge clk); #1;

      // Reset mid-read; old read's mfc lands inside the new read's ignore window
      do_reset();
      ra[0] = 16'h0000; rq = 4'b0001; apply();
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0; rq = 4'b0; apply();
      #1;
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_strobe", 32'(mem_strobe_o), 32'd0);
      #1 rst_n = 1'b1; ra[0] = 16'h0001; rq = 4'b0001; apply();
      watch(12, 1'b1);
      chk("mid_rst_events", 32'(ev_n), 32'd1);
      chk("mid_rst_new", {ev_mask[0], 12'(ev_edge[0]), ev_data[0]}, {4'b0001, 12'd6, 16'h1345});
      rq = 4'b0; apply(); repeat (6) @(posedge clk); #1;

`ifdef MEMSCHED_TIMEOUT_EN
      do_reset();
      mfc_block = 1; ra[0] = 16'h0000; rq = 4'b0001; apply();
      watch(24, 1'b1);
      chk("to_events", 32'(ev_n), 32'd1);
      chk("to_done", {ev_mask[0], 12'(ev_edge[0]), ev_data[0]}, {4'b0001, 12'(TO + 1), 16'hFFFF});
      mfc_block = 0;
      rq = 4'b0; apply(); repeat (3) @(posedge clk); #1;
`endif

      // Randomized run against an edge-level scoreboard
      do_reset();
      for (int i = 0; i < 256; i++) shad[i] = m[i];
      nf = 0; ld = -100; lg = -100; li = -1; fp = 0; dp = 0;
      exp_edge = -1; exp_idx = 0; exp_rd = 0; exp_data = 16'h0;
      for (int k = 0; k < 1500; k++) begin
         if (k >= nf) begin
            logic [3:0] el;
            int cls, pid;
            el = rq;
            if (k == ld + 1 && li >= 0) el[li] = 1'b0;
            cls = -1; pid = 0;
            if (el[3] | el[2]) begin
               cls = 1;
               pid = (el[3] & el[2]) ? int'(dp) : int'(el[3]);
               dp = (pid == 0);
            end else if (el[1] | el[0]) begin
               cls = 0;
               pid = (el[1] & el[0]) ? int'(fp) : int'(el[1]);
               fp = (pid == 0);
            end
            if (cls >= 0) begin
               int lat;
               exp_idx  = cls * 2 + pid;
               exp_rd   = (exp_idx < 2) ? 1'b1 : rw[exp_idx];
               exp_data = shad[ra[exp_idx][7:0]];
               if (!exp_rd) shad[ra[exp_idx][7:0]] = wd[exp_idx];
               lat = exp_rd ? 6 : 1;
               exp_edge = k + lat; lg = k; ld = k + lat; nf = k + lat + 1; li = exp_idx;
            end
         end
         @(posedge clk); #1;
         chk("rnd_done", 32'(done_o), (k == exp_edge) ? (32'd1 << exp_idx) : 32'd0);
         if (k == exp_edge && exp_rd) chk("rnd_rdata", 32'(rdata_o), 32'(exp_data));
         chk("rnd_busy", 32'(busy_o), 32'(k >= lg && k <= ld));
         chk("rnd_strobe", 32'(mem_strobe_o), 32'(k == lg));
         chk("rnd_err", 32'(err_o), 32'd0);
         for (int i = 0; i < 4; i++) begin
            if (done_o[i] && ($urandom_range(1) == 0)) rq[i] = 1'b0;
            else if (done_o[i] || (!rq[i] && $urandom_range(3) == 0)) begin
               rq[i] = 1'b1;
               ra[i] = 16'($urandom_range(15));
               wd[i] = 16'($urandom);
               rw[i] = (i < 2) ? 1'b1 : 1'($urandom_range(1));
            end
         end
         apply();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
